// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR tap window: sample width, window FSM
// states and the fill-counter width function.
package fir_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      EMPTY,
      FILL,
      STREAM
   } tap_win_state_t;

   // Width needed to hold the values 0..n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/tap_shift_reg.sv
// Parallel-out delay line: q[0] is the newest sample and q[N-1] the oldest.
// The synchronous clear zeroes every tap.
module tap_shift_reg #(
   parameter int N = 8,
   parameter int W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                shift_en,
   input  logic signed [W-1:0] d,
   output logic signed [W-1:0] q [0:N-1]
);

   logic signed [W-1:0] src [0:N-1];

   assign src[0] = d;

   for (genvar i = 0; i < N; i++) begin : g_tap
      if (i > 0) begin : g_src
         assign src[i] = q[i-1];
      end

      always_ff @(posedge clk) begin
         if (rst || clr) begin
            q[i] <= '0;
         end else if (shift_en) begin
            q[i] <= src[i];
         end
      end
   end

endmodule

// File: rtl/fir_tap_window.sv
// Sliding N-tap sample window with valid/ready handshakes on both sides.
// Define FIR_TAP_WINDOW_PRIME_EN to present a window after every accept, not only once full.
module fir_tap_window
   import fir_pkg::*;
#(
   parameter int N = 8,
   parameter int W = DATA_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic signed [W-1:0]      s_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic signed [W-1:0]      m_taps [0:N-1],
   output logic [cnt_w(N)-1:0]      fill_count
);

   localparam int CW = cnt_w(N);
   localparam logic [CW-1:0] FULL = CW'(N);

`ifdef FIR_TAP_WINDOW_PRIME_EN
   localparam bit PRIME = 1'b1;
`else
   localparam bit PRIME = 1'b0;
`endif

   tap_win_state_t  state, state_nxt;
   logic [CW-1:0]   fill_nxt;
   logic            m_valid_nxt;
   logic            accept;

   // A pending window blocks the input until it is consumed, with no bubble.
   assign s_ready = (!m_valid || m_ready) && !flush;
   assign accept  = s_valid && s_ready && !flush;

   always_comb begin
      state_nxt   = state;
      fill_nxt    = fill_count;
      m_valid_nxt = m_valid;
      if (flush) begin
         state_nxt   = EMPTY;
         fill_nxt    = '0;
         m_valid_nxt = 1'b0;
      end else if (accept) begin
         if (fill_count != FULL) begin
            fill_nxt = fill_count + CW'(1);
         end
         unique case (state)
            EMPTY:   state_nxt = (fill_nxt == FULL) ? STREAM : FILL;
            FILL:    state_nxt = (fill_nxt == FULL) ? STREAM : FILL;
            STREAM:  state_nxt = STREAM;
            default: state_nxt = EMPTY;
         endcase
         m_valid_nxt = PRIME || (fill_nxt == FULL);
      end else if (m_valid && m_ready) begin
         m_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         fill_count <= '0;
         m_valid    <= 1'b0;
      end else begin
         state      <= state_nxt;
         fill_count <= fill_nxt;
         m_valid    <= m_valid_nxt;
      end
   end

   tap_shift_reg #(
      .N (N),
      .W (W)
   ) u_taps (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .shift_en (accept),
      .d        (s_data),
      .q        (m_taps)
   );

endmodule

// File: tb/tb_fir_tap_window.sv
// Directed bench for fir_tap_window (N=8, W=32): fill table plus hand
// sequences for backpressure, flush, mid-stream reset and saturation.
module tb_fir_tap_window;

   localparam int N = 8;
   localparam int W = 32;

`ifdef FIR_TAP_WINDOW_PRIME_EN
   localparam bit PRIME = 1'b1;
`else
   localparam bit PRIME = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                flush = 1'b0;
   logic                s_valid = 1'b0;
   logic                s_ready;
   logic signed [W-1:0] s_data = '0;
   logic                m_valid;
   logic                m_ready = 1'b0;
   logic signed [W-1:0] m_taps [0:N-1];
   logic [3:0]          fill_count;

   int checks = 0;
   int errors = 0;

   fir_tap_window #(.N(N), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_taps     (m_taps),
      .fill_count (fill_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r, f, sv, mr;
      logic [31:0] sd;
      logic        e_srdy, e_mv;
      logic [31:0] e_fill, e_tap0;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic sv,
                        input logic [31:0] sd, input logic mr);
      rst = r; flush = f; s_valid = sv; s_data = sd; m_ready = mr;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string nm);
      for (int i = 0; i < N; i++) chk($sformatf("%s_tap%0d", nm, i), m_taps[i], 0);
   endtask

   task automatic feed(input int first, input int last);
      for (int k = first; k <= last; k++) begin
         drive(0, 0, 1, k, 1);
         step();
      end
   endtask

   initial begin
      // fill sequence with an idle gap after sample 4
      for (int k = 1; k <= 4; k++)
         tbl[k-1] = '{r:0, f:0, sv:1, mr:1, sd:k, e_srdy:1, e_mv:PRIME, e_fill:k, e_tap0:k};
      tbl[4] = '{r:0, f:0, sv:0, mr:1, sd:77, e_srdy:1, e_mv:0, e_fill:4, e_tap0:4};
      for (int k = 5; k <= 8; k++)
         tbl[k] = '{r:0, f:0, sv:1, mr:1, sd:k, e_srdy:1, e_mv:(PRIME || k == 8),
                    e_fill:k, e_tap0:k};

      @(posedge clk); #1;
      drive(1, 0, 0, 0, 0);
      step(); step();
      drive(0, 0, 0, 0, 0);
      chk("rst_mvalid", m_valid, 0);
      chk("rst_fill", fill_count, 0);
      chk("rst_sready", s_ready, 1);
      chk("rst_state", dut.state, 0);
      chk_zero("rst");

      // single sample: primed window or nothing
      drive(0, 0, 1, 5, 1);
      step();
      chk("one_mvalid", m_valid, PRIME);
      chk("one_fill", fill_count, 1);
      chk("one_tap0", m_taps[0], 5);
      for (int i = 1; i < N; i++) chk($sformatf("one_tap%0d", i), m_taps[i], 0);
      drive(0, 1, 0, 0, 1);
      step();
      chk("clr_fill", fill_count, 0);

      for (int v = 0; v < 9; v++) begin
         drive(tbl[v].r, tbl[v].f, tbl[v].sv, tbl[v].sd, tbl[v].mr);
         chk($sformatf("vec%0d_sready", v), s_ready, tbl[v].e_srdy);
         step();
         chk($sformatf("vec%0d_mvalid", v), m_valid, tbl[v].e_mv);
         chk($sformatf("vec%0d_fill", v), fill_count, tbl[v].e_fill);
         chk($sformatf("vec%0d_tap0", v), m_taps[0], tbl[v].e_tap0);
      end
      for (int i = 0; i < N; i++) chk($sformatf("full_tap%0d", i), m_taps[i], 8 - i);

      // backpressure: sample 9 held upstream for 4 stalled cycles
      for (int c = 0; c < 4; c++) begin
         drive(0, 0, 1, 9, 0);
         chk("bp_sready", s_ready, 0);
         step();
         chk("bp_mvalid", m_valid, 1);
         chk("bp_tap0", m_taps[0], 8);
         chk("bp_tap7", m_taps[7], 1);
      end
      drive(0, 0, 1, 9, 1);
      chk("rel_sready", s_ready, 1);
      step();
      chk("rel_mvalid", m_valid, 1);
      chk("rel_tap0", m_taps[0], 9);
      chk("rel_tap1", m_taps[1], 8);
      chk("rel_tap7", m_taps[7], 2);
      drive(0, 0, 1, 10, 1);
      step();
      chk("rel2_mvalid", m_valid, 1);
      chk("rel2_tap0", m_taps[0], 10);
      chk("rel2_tap7", m_taps[7], 3);
      drive(0, 0, 0, 0, 1);
      step();
      chk("drain_mvalid", m_valid, 0);
      chk("drain_tap0", m_taps[0], 10);

      // flush beats a valid sample
      drive(0, 0, 1, 11, 0);
      step();
      drive(0, 1, 1, 99, 1);
      chk("fl_sready", s_ready, 0);
      step();
      chk("fl_mvalid", m_valid, 0);
      chk("fl_fill", fill_count, 0);
      chk("fl_state", dut.state, 0);
      chk_zero("fl");
      drive(0, 0, 0, 0, 1);
      step();
      chk("fl2_tap0", m_taps[0], 0);

      // reset with a pending stalled window
      feed(1, 8);
      drive(0, 0, 0, 0, 0);
      step();
      chk("pre_rst_mvalid", m_valid, 1);
      drive(1, 0, 1, 55, 0);
      step();
      drive(0, 0, 0, 0, 0);
      chk("mrst_mvalid", m_valid, 0);
      chk("mrst_fill", fill_count, 0);
      chk("mrst_sready", s_ready, 1);
      chk_zero("mrst");

      // saturation
      feed(1, 20);
      drive(0, 0, 0, 0, 0);
      chk("sat_fill", fill_count, 8);
      chk("sat_mvalid", m_valid, 1);
      for (int i = 0; i < N; i++) chk($sformatf("sat_tap%0d", i), m_taps[i], 20 - i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
